// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button input stage.
package key_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } key_state_t;

  localparam int KEY_DEBOUNCE_DEF = 500000;
  localparam int KEY_REPEAT_DEF   = 25000000;

endpackage

// File: rtl/key_filter.sv
// One push-button channel: 2-flop synchroniser followed by a counting
// debounce FSM; level only moves after DEBOUNCE_CYCLES identical samples.
module key_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_filter: DEBOUNCE_CYCLES must be at least 2");
  end

  logic             s1_q, s2_q;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = CHK_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = CHK_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // The raw pin is asynchronous, so only s2_q may feed the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/key_debounce.sv
// Debounced data/clock keys for the LED register bank; strobe marks each
// accepted clock-key press. Define KEY_AUTOREPEAT_EN for held-key repeat.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_CYCLES   = KEY_REPEAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_d,
  input  logic key_clk,
  output logic d_out,
  output logic strobe,
  output logic d_led,
  output logic clk_led
);

  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("key_debounce: REPEAT_CYCLES must be at least 1");
  end

  logic d_level, clk_level;
  logic clk_prev_q, clk_prev_d;
  logic strobe_q, strobe_d;

  key_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_filter_d (
    .clk  (clk),
    .rst  (rst),
    .raw  (key_d),
    .level(d_level)
  );

  key_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_filter_clk (
    .clk  (clk),
    .rst  (rst),
    .raw  (key_clk),
    .level(clk_level)
  );

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Counter holds the cycles since the last strobe while the key stays accepted.
  always_comb begin
    clk_prev_d = clk_level;
    strobe_d   = clk_level & ~clk_prev_q;
    rep_cnt_d  = '0;
    if (clk_level) begin
      if (rep_cnt_q == REP_W'(REPEAT_CYCLES)) begin
        rep_cnt_d = REP_W'(1);
        strobe_d  = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  always_comb begin
    clk_prev_d = clk_level;
    strobe_d   = clk_level & ~clk_prev_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      clk_prev_q <= clk_prev_d;
      strobe_q   <= strobe_d;
    end
  end

  // Strobe lags the level by one edge, so data accepted together is already visible.
  assign d_out   = d_level;
  assign d_led   = d_level;
  assign clk_led = clk_level;
  assign strobe  = strobe_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a sample-history reference model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_key_debounce;

  localparam int DEB = 4;
  localparam int REP = 10;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic key_d   = 1'b0;
  logic key_clk = 1'b0;
  logic d_out, strobe, d_led, clk_led;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_d  (key_d),
    .key_clk(key_clk),
    .d_out  (d_out),
    .strobe (strobe),
    .d_led  (d_led),
    .clk_led(clk_led)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycleNo    = 0;
  logic [3:0] expQ[$];

  // Reference model state: raw samples since the last reset, one per edge.
  bit histD[$];
  bit histC[$];
  int edgeIdx  = 0;
  bit lvlD     = 1'b0;
  bit lvlC     = 1'b0;
  int accEdge  = -100000;

  // A key's level flips once the synchronised view (raw delayed two edges)
  // has shown the opposite level for DEB consecutive edges.
  function automatic bit accepted(input bit useClk, input bit target);
    bit s;
    for (int k = edgeIdx - DEB - 1; k <= edgeIdx - 2; k++) begin
      if (k < 0) s = 1'b0;
      else s = useClk ? histC[k] : histD[k];
      if (s != target) return 1'b0;
    end
    return 1'b1;
  endfunction

  function void modelStep(input bit d, input bit c, input bit r);
    bit strobeExp;
    if (r) begin
      histD.delete();
      histC.delete();
      edgeIdx = 0;
      lvlD    = 1'b0;
      lvlC    = 1'b0;
      accEdge = -100000;
      expQ.push_back(4'b0000);
      return;
    end
    histD.push_back(d);
    histC.push_back(c);
`ifdef KEY_AUTOREPEAT_EN
    strobeExp = lvlC && (edgeIdx - 1 - accEdge >= 0) && ((edgeIdx - 1 - accEdge) % REP == 0);
`else
    strobeExp = lvlC && (edgeIdx - 1 == accEdge);
`endif
    if (accepted(1'b0, !lvlD)) lvlD = !lvlD;
    if (accepted(1'b1, !lvlC)) begin
      lvlC = !lvlC;
      if (lvlC) accEdge = edgeIdx;
    end
    edgeIdx++;
    expQ.push_back({lvlD, lvlD, lvlC, strobeExp});
  endfunction

  task automatic applyStimulus(input bit d, input bit c, input bit r, input int n);
    repeat (n) begin
      @(negedge clk);
      key_d   = d;
      key_clk = c;
      rst     = r;
      modelStep(d, c, r);
    end
  endtask

  task automatic checkOutput(input logic [3:0] expected);
    logic [3:0] actual;
    actual = {d_out, d_led, clk_led, strobe};
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL outputs{d_out,d_led,clk_led,strobe} cycle %0d: got %b, expected %b",
               cycleNo, actual, expected);
    end
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    // Power-on reset and idle.
    applyStimulus(0, 0, 1, 3);
    applyStimulus(0, 0, 0, 5);
    // Clean press and release: no strobe on release.
    applyStimulus(0, 1, 0, 20);
    applyStimulus(0, 0, 0, 12);
    // Bouncing data key then settling high.
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(1, 0, 0, 12);
    applyStimulus(0, 0, 0, 12);
    // Short clock-key glitch is rejected.
    applyStimulus(0, 1, 0, 3);
    applyStimulus(0, 0, 0, 10);
    // Both keys rise together; strobe must see new d_out.
    applyStimulus(1, 1, 0, 12);
    applyStimulus(0, 0, 0, 12);
    // Reset while the clock-key filter is qualifying, key still held.
    applyStimulus(0, 1, 0, 4);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 0, 12);
    applyStimulus(0, 0, 0, 10);
    // Long hold: auto-repeat strobes when enabled, single strobe otherwise.
    applyStimulus(0, 1, 0, 45);
    applyStimulus(0, 0, 0, 10);
    // Random bouncing with occasional resets.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0)
        applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1,
                      int'($urandom_range(1, 2)));
      else
        applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0,
                      int'($urandom_range(1, 12)));
    end
    applyStimulus(0, 0, 0, 10);
    for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
